// File: rtl/lfsr_checker.sv
// lfsr_checker: lock detector and bit-error counter
// for a serial x^26+x^6+x^2+x+1 PRBS stream.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      async active-low reset
//   din_valid  qualifies din; low holds all state
//   din        serial PRBS bit under test
//   clear      sync clear of error statistics
//   locked     high while in LOCKED
//   err_flag   one-cycle pulse per locked mismatch
//   err_cnt    saturating locked mismatch count
//   stuck_zero history all zero outside FILL
//   state      00 FILL, 01 VERIFY, 10 LOCKED
module lfsr_checker #(
  parameter int LOCK_MATCH = 32,
  parameter int LOSS_ERR   = 8,
  parameter int WINDOW     = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        din_valid,
  input  logic        din,
  input  logic        clear,
  output logic        locked,
  output logic        err_flag,
  output logic [15:0] err_cnt,
  output logic        stuck_zero,
  output logic [1:0]  state
);

  localparam int MW = $clog2(LOCK_MATCH + 1);
  localparam int WW = (WINDOW > 1) ? $clog2(WINDOW) : 1;
  localparam int EW = $clog2(LOSS_ERR + 1);

  localparam logic [MW-1:0] MATCH_LAST = MW'(LOCK_MATCH - 1);
  localparam logic [WW-1:0] WIN_LAST   = WW'(WINDOW - 1);
  localparam logic [EW-1:0] ERR_LIMIT  = EW'(LOSS_ERR);
  localparam logic [4:0]    FILL_LAST  = 5'd25;

  typedef enum logic [1:0] {
    FILL   = 2'b00,
    VERIFY = 2'b01,
    LOCKED = 2'b10
  } state_t;

  state_t        st;
  logic [25:0]   hist;
  logic [4:0]    fill_cnt;
  logic [MW-1:0] match_cnt;
  logic [WW-1:0] win_cnt;
  logic [EW-1:0] win_err;

  logic          pred;
  logic          miss;
  logic          hist_zero;
  logic          win_wrap;
  logic [EW-1:0] win_err_nxt;
  logic          lose;

  // hist[0] is the newest bit, hist[k-1] is s[n-k]
  assign pred = hist[0] ^ hist[1]
              ^ hist[5] ^ hist[25];

  assign miss      = din ^ pred;
  assign hist_zero = (hist == '0);
  assign win_wrap  = (win_cnt == WIN_LAST);

  // an error on the wrapping bit lands
  // in the window that starts there
  assign win_err_nxt =
    (win_wrap ? '0 : win_err) + EW'(miss);

  // a clear on the same bit discards the
  // window tally, so it cannot drop lock
  assign lose = !clear
             && (win_err_nxt == ERR_LIMIT);

  assign state      = st;
  assign stuck_zero = (st != FILL)
                   && hist_zero;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st        <= FILL;
      hist      <= '0;
      fill_cnt  <= '0;
      match_cnt <= '0;
      win_cnt   <= '0;
      win_err   <= '0;
      locked    <= 1'b0;
      err_flag  <= 1'b0;
      err_cnt   <= '0;
    end else begin
      err_flag <= 1'b0;
      if (din_valid) begin
        unique case (st)
          FILL: begin
            hist <= {hist[24:0], din};
            if (fill_cnt == FILL_LAST) begin
              st        <= VERIFY;
              fill_cnt  <= '0;
              match_cnt <= '0;
            end else begin
              fill_cnt <= fill_cnt + 5'd1;
            end
          end

          VERIFY: begin
            hist <= {hist[24:0], din};
            if (!miss && !hist_zero) begin
              if (match_cnt == MATCH_LAST) begin
                st        <= LOCKED;
                locked    <= 1'b1;
                match_cnt <= '0;
                win_cnt   <= '0;
                win_err   <= '0;
              end else begin
                match_cnt <= match_cnt + MW'(1);
              end
            end else begin
              match_cnt <= '0;
            end
          end

          LOCKED: begin
            // flywheel: run on prediction so a
            // single bad bit is not re-seen
            hist     <= {hist[24:0], pred};
            err_flag <= miss;
            if (miss && err_cnt != 16'hFFFF)
              err_cnt <= err_cnt + 16'd1;
            if (win_wrap)
              win_cnt <= '0;
            else
              win_cnt <= win_cnt + WW'(1);
            win_err <= win_err_nxt;
            if (lose) begin
              st        <= FILL;
              locked    <= 1'b0;
              fill_cnt  <= '0;
              match_cnt <= '0;
              win_cnt   <= '0;
              win_err   <= '0;
            end
          end

          default: begin
            st     <= FILL;
            locked <= 1'b0;
          end
        endcase

        if (clear) begin
          err_cnt <= '0;
          win_cnt <= '0;
          win_err <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_lfsr_checker.sv
// tb_lfsr_checker: directed and randomized checks
// of lfsr_checker against a queue-based model.
module tb_lfsr_checker;

  localparam int LOCK_MATCH = 32;
  localparam int LOSS_ERR   = 8;
  localparam int WINDOW     = 64;
  localparam int SEQ_LEN    = 8192;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        din_valid = 1'b0;
  logic        din = 1'b0;
  logic        clear = 1'b0;
  logic        locked;
  logic        err_flag;
  logic [15:0] err_cnt;
  logic        stuck_zero;
  logic [1:0]  state;

  int checks = 0;
  int failures = 0;

  bit seq [0:SEQ_LEN-1];
  int pos;

  // reference model
  bit mh[$];
  int m_mode;
  int m_fill;
  int m_run;
  int m_wbits;
  int m_werr;
  int m_errs;
  bit m_flag;

  lfsr_checker #(
    .LOCK_MATCH(LOCK_MATCH),
    .LOSS_ERR(LOSS_ERR),
    .WINDOW(WINDOW)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .din_valid(din_valid),
    .din(din),
    .clear(clear),
    .locked(locked),
    .err_flag(err_flag),
    .err_cnt(err_cnt),
    .stuck_zero(stuck_zero),
    .state(state)
  );

  always #5 clk = ~clk;

  function automatic bit hist_any();
    for (int i = 0; i < mh.size(); i++)
      if (mh[i]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_reset();
    mh.delete();
    for (int i = 0; i < 26; i++) mh.push_back(1'b0);
    m_mode = 0;
    m_fill = 0;
    m_run = 0;
    m_wbits = 0;
    m_werr = 0;
    m_errs = 0;
    m_flag = 1'b0;
  endtask

  task automatic model_push(input bit x);
    mh.push_back(x);
    void'(mh.pop_front());
  endtask

  task automatic model_step(input bit b, input bit v,
                            input bit clr);
    bit p;
    bit any;
    bit miss;
    m_flag = 1'b0;
    if (!v) return;
    // newest bit at the back: s[n-1] is mh[25]
    p = mh[25] ^ mh[24] ^ mh[20] ^ mh[0];
    any = hist_any();
    if (m_mode == 0) begin
      model_push(b);
      m_fill++;
      if (m_fill == 26) begin
        m_mode = 1;
        m_fill = 0;
        m_run = 0;
      end
    end else if (m_mode == 1) begin
      model_push(b);
      if (b == p && any) begin
        m_run++;
        if (m_run == LOCK_MATCH) begin
          m_mode = 2;
          m_run = 0;
          m_wbits = 0;
          m_werr = 0;
        end
      end else begin
        m_run = 0;
      end
    end else begin
      model_push(p);
      miss = (b != p);
      m_flag = miss;
      if (m_wbits == WINDOW - 1) m_werr = 0;
      m_wbits = (m_wbits + 1) % WINDOW;
      if (miss) begin
        m_werr++;
        if (m_errs < 65535) m_errs++;
      end
      if (!clr && m_werr == LOSS_ERR) begin
        m_mode = 0;
        m_fill = 0;
        m_run = 0;
        m_wbits = 0;
        m_werr = 0;
      end
    end
    if (clr) begin
      m_errs = 0;
      m_wbits = 0;
      m_werr = 0;
    end
  endtask

  task automatic send(input bit b, input bit v,
                      input bit clr);
    din = b;
    din_valid = v;
    clear = clr;
    @(posedge clk);
    #1;
    model_step(b, v, clr);
  endtask

  task automatic feed(input bit inv, input bit clr);
    send(seq[pos] ^ inv, 1'b1, clr);
    pos++;
  endtask

  task automatic do_reset();
    din_valid = 1'b0;
    din = 1'b0;
    clear = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic lock_up();
    do_reset();
    pos = $urandom_range(0, 1000);
    for (int i = 0; i < 58; i++) feed(1'b0, 1'b0);
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (state !== 2'b00 || locked !== 1'b0 ||
        err_flag !== 1'b0 || err_cnt !== 16'h0 ||
        stuck_zero !== 1'b0) begin
      failures++;
      $display("FAIL reset: st=%b lk=%b fl=%b cnt=%0d sz=%b, expected all zero",
               state, locked, err_flag, err_cnt, stuck_zero);
    end
  endtask

  task automatic test_clean_lock();
    do_reset();
    pos = $urandom_range(0, 1000);
    for (int k = 1; k <= 70; k++) begin
      feed(1'b0, 1'b0);
      if (k == 25) begin
        checks++;
        if (state !== 2'b00) begin
          failures++;
          $display("FAIL fill_25: state=%b expected 00", state);
        end
      end
      if (k == 26) begin
        checks++;
        if (state !== 2'b01) begin
          failures++;
          $display("FAIL verify_26: state=%b expected 01", state);
        end
      end
      if (k == 57) begin
        checks++;
        if (locked !== 1'b0) begin
          failures++;
          $display("FAIL lock_57: locked=%b expected 0", locked);
        end
      end
      if (k == 58) begin
        checks++;
        if (locked !== 1'b1 || state !== 2'b10) begin
          failures++;
          $display("FAIL lock_58: locked=%b state=%b expected 1/10",
                   locked, state);
        end
      end
    end
    checks++;
    if (err_cnt !== 16'h0 || err_flag !== 1'b0) begin
      failures++;
      $display("FAIL clean_errs: cnt=%0d flag=%b expected 0/0",
               err_cnt, err_flag);
    end
  endtask

  task automatic test_single_error();
    int pulses;
    lock_up();
    for (int i = 0; i < 10; i++) feed(1'b0, 1'b0);
    feed(1'b1, 1'b0);
    checks++;
    if (err_flag !== 1'b1 || err_cnt !== 16'd1 ||
        locked !== 1'b1) begin
      failures++;
      $display("FAIL single_hit: flag=%b cnt=%0d lk=%b expected 1/1/1",
               err_flag, err_cnt, locked);
    end
    pulses = 0;
    for (int i = 0; i < 100; i++) begin
      feed(1'b0, 1'b0);
      if (err_flag === 1'b1) pulses++;
    end
    checks++;
    if (pulses != 0 || err_cnt !== 16'd1 ||
        locked !== 1'b1) begin
      failures++;
      $display("FAIL single_after: pulses=%0d cnt=%0d lk=%b expected 0/1/1",
               pulses, err_cnt, locked);
    end
  endtask

  task automatic test_loss();
    lock_up();
    for (int e = 1; e <= 8; e++) begin
      feed(1'b1, 1'b0);
      if (e == 7) begin
        checks++;
        if (locked !== 1'b1) begin
          failures++;
          $display("FAIL loss_7: locked=%b expected 1", locked);
        end
      end
      if (e < 8) begin
        feed(1'b0, 1'b0);
        feed(1'b0, 1'b0);
      end
    end
    checks++;
    if (locked !== 1'b0 || state !== 2'b00 ||
        err_cnt !== 16'd8) begin
      failures++;
      $display("FAIL loss_8: lk=%b st=%b cnt=%0d expected 0/00/8",
               locked, state, err_cnt);
    end
    for (int k = 1; k <= 58; k++) begin
      feed(1'b0, 1'b0);
      if (k == 57) begin
        checks++;
        if (locked !== 1'b0) begin
          failures++;
          $display("FAIL relock_57: locked=%b expected 0", locked);
        end
      end
    end
    checks++;
    if (locked !== 1'b1 || err_cnt !== 16'd8) begin
      failures++;
      $display("FAIL relock_58: lk=%b cnt=%0d expected 1/8",
               locked, err_cnt);
    end
  endtask

  task automatic test_window_wrap();
    // errors 57..62 end window 0; 63 is the
    // wrapping bit and opens window 1 with 63..70
    lock_up();
    for (int i = 0; i <= 70; i++) begin
      feed((i >= 57) ? 1'b1 : 1'b0, 1'b0);
      if (i == 69) begin
        checks++;
        if (locked !== 1'b1 || err_cnt !== 16'd13) begin
          failures++;
          $display("FAIL wrap_69: lk=%b cnt=%0d expected 1/13",
                   locked, err_cnt);
        end
      end
    end
    checks++;
    if (locked !== 1'b0 || err_cnt !== 16'd14) begin
      failures++;
      $display("FAIL wrap_70: lk=%b cnt=%0d expected 0/14",
               locked, err_cnt);
    end
  endtask

  task automatic test_stuck_zero();
    int bad;
    do_reset();
    for (int k = 1; k <= 26; k++) begin
      send(1'b0, 1'b1, 1'b0);
      if (k == 25) begin
        checks++;
        if (stuck_zero !== 1'b0) begin
          failures++;
          $display("FAIL stuck_25: sz=%b expected 0", stuck_zero);
        end
      end
    end
    bad = 0;
    for (int k = 0; k < 100; k++) begin
      if (stuck_zero !== 1'b1 || locked !== 1'b0 ||
          err_cnt !== 16'h0) bad++;
      send(1'b0, 1'b1, 1'b0);
    end
    checks++;
    if (bad != 0 || stuck_zero !== 1'b1) begin
      failures++;
      $display("FAIL stuck_run: bad_cycles=%0d sz=%b expected 0/1",
               bad, stuck_zero);
    end
  endtask

  task automatic test_clear_collision();
    lock_up();
    feed(1'b0, 1'b0);
    feed(1'b1, 1'b0);
    feed(1'b0, 1'b0);
    feed(1'b1, 1'b0);
    checks++;
    if (err_cnt !== 16'd2) begin
      failures++;
      $display("FAIL clr_pre: cnt=%0d expected 2", err_cnt);
    end
    feed(1'b1, 1'b1);
    checks++;
    if (err_flag !== 1'b1 || err_cnt !== 16'h0 ||
        locked !== 1'b1) begin
      failures++;
      $display("FAIL clr_hit: flag=%b cnt=%0d lk=%b expected 1/0/1",
               err_flag, err_cnt, locked);
    end
    feed(1'b0, 1'b0);
    checks++;
    if (err_flag !== 1'b0 || err_cnt !== 16'h0) begin
      failures++;
      $display("FAIL clr_next: flag=%b cnt=%0d expected 0/0",
               err_flag, err_cnt);
    end
    for (int e = 0; e < 7; e++) begin
      feed(1'b1, 1'b0);
      feed(1'b0, 1'b0);
    end
    checks++;
    if (locked !== 1'b1 || err_cnt !== 16'd7) begin
      failures++;
      $display("FAIL clr_win7: lk=%b cnt=%0d expected 1/7",
               locked, err_cnt);
    end
    feed(1'b1, 1'b0);
    checks++;
    if (locked !== 1'b0 || err_cnt !== 16'd8) begin
      failures++;
      $display("FAIL clr_win8: lk=%b cnt=%0d expected 0/8",
               locked, err_cnt);
    end
  endtask

  task automatic test_reset_midlock();
    lock_up();
    for (int e = 0; e < 5; e++) begin
      feed(1'b1, 1'b0);
      feed(1'b0, 1'b0);
    end
    checks++;
    if (err_cnt !== 16'd5 || locked !== 1'b1) begin
      failures++;
      $display("FAIL mid_pre: cnt=%0d lk=%b expected 5/1",
               err_cnt, locked);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (locked !== 1'b0 || err_cnt !== 16'h0 ||
        state !== 2'b00 || stuck_zero !== 1'b0) begin
      failures++;
      $display("FAIL mid_async: lk=%b cnt=%0d st=%b sz=%b expected 0/0/00/0",
               locked, err_cnt, state, stuck_zero);
    end
    do_reset();
    for (int k = 1; k <= 58; k++) begin
      feed(1'b0, 1'b0);
      if (k == 57) begin
        checks++;
        if (locked !== 1'b0) begin
          failures++;
          $display("FAIL mid_57: locked=%b expected 0", locked);
        end
      end
    end
    checks++;
    if (locked !== 1'b1 || err_cnt !== 16'h0) begin
      failures++;
      $display("FAIL mid_58: lk=%b cnt=%0d expected 1/0",
               locked, err_cnt);
    end
  endtask

  task automatic test_valid_gap();
    do_reset();
    pos = $urandom_range(0, 1000);
    for (int i = 0; i < 10; i++) feed(1'b0, 1'b0);
    for (int i = 0; i < 20; i++)
      send(1'($urandom_range(0, 1)), 1'b0, 1'b0);
    for (int i = 0; i < 16; i++) feed(1'b0, 1'b0);
    checks++;
    if (state !== 2'b01) begin
      failures++;
      $display("FAIL gap_fill: state=%b expected 01", state);
    end
    for (int i = 0; i < 32; i++) feed(1'b0, 1'b0);
    feed(1'b1, 1'b0);
    send(1'b1, 1'b0, 1'b1);
    checks++;
    if (err_flag !== 1'b0 || err_cnt !== 16'd1 ||
        state !== 2'b10) begin
      failures++;
      $display("FAIL gap_hold: flag=%b cnt=%0d st=%b expected 0/1/10",
               err_flag, err_cnt, state);
    end
    for (int i = 0; i < 40; i++) begin
      if (i % 3 == 0)
        send(1'($urandom_range(0, 1)), 1'b0, 1'b0);
      feed(1'b0, 1'b0);
    end
    checks++;
    if (err_cnt !== 16'd1 || locked !== 1'b1) begin
      failures++;
      $display("FAIL gap_resume: cnt=%0d lk=%b expected 1/1",
               err_cnt, locked);
    end
  endtask

  task automatic test_random();
    bit v;
    bit b;
    bit clr;
    bit flip;
    bit exp_sz;
    int rate;
    int shown;
    do_reset();
    pos = 0;
    shown = 0;
    for (int c = 0; c < 3000; c++) begin
      rate = ((c / 500) % 2 == 1) ? 15 : 1;
      v = ($urandom_range(0, 9) != 0);
      flip = ($urandom_range(0, 99) < rate);
      clr = v && ($urandom_range(0, 199) == 0);
      if (v) begin
        b = seq[pos] ^ flip;
        pos++;
      end else begin
        b = 1'($urandom_range(0, 1));
      end
      send(b, v, clr);
      exp_sz = (m_mode != 0) && !hist_any();
      checks++;
      if (state !== 2'(m_mode) || locked !== (m_mode == 2) ||
          err_flag !== m_flag || err_cnt !== 16'(m_errs) ||
          stuck_zero !== exp_sz) begin
        failures++;
        if (shown < 20)
          $display("FAIL random_c%0d: st=%b lk=%b fl=%b cnt=%0d sz=%b expected st=%0d fl=%b cnt=%0d sz=%b",
                   c, state, locked, err_flag, err_cnt, stuck_zero,
                   m_mode, m_flag, m_errs, exp_sz);
        shown++;
      end
    end
  endtask

  initial begin
    logic [25:0] seed;
    seed = 26'b01_1001_0011_1000_0011_1111_0010;
    for (int i = 0; i < 26; i++) seq[i] = seed[25-i];
    for (int i = 26; i < SEQ_LEN; i++)
      seq[i] = seq[i-1] ^ seq[i-2] ^ seq[i-6] ^ seq[i-26];
    model_reset();

    test_reset();
    test_clean_lock();
    test_single_error();
    test_loss();
    test_window_wrap();
    test_stuck_zero();
    test_clear_collision();
    test_reset_midlock();
    test_valid_gap();
    test_random();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lfsr_checker.md
LFSR_CHECKER -- requirements
Module: lfsr_checker

Interface
REQ-001 Parameter LOCK_MATCH, default 32: consecutive correct predictions required to declare lock.
REQ-002 Parameter LOSS_ERR, default 8: errors within one window that force loss of lock.
REQ-003 Parameter WINDOW, default 64: valid bits per error-counting window while locked.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 din_valid  input  1  qualifies din; when low, no internal state changes.
REQ-007 din  input  1  serial bit from the upstream 26-bit LFSR (its q[26] output).
REQ-008 clear  input  1  synchronous clear of error statistics.
REQ-009 locked  output  1  registered; high while in LOCKED state.
REQ-010 err_flag  output  1  registered one-cycle pulse per mismatch detected while LOCKED.
REQ-011 err_cnt  output  16  saturating count of mismatches detected while LOCKED.
REQ-012 stuck_zero  output  1  high while history register is all zeros and state is not FILL.
REQ-013 state  output  2  debug view: 00 FILL, 01 VERIFY, 10 LOCKED.

Function
REQ-014 Reference sequence SHALL satisfy s[n] = s[n-1] ^ s[n-2] ^ s[n-6] ^ s[n-26] (x^26+x^6+x^2+x+1).
REQ-015 Block SHALL keep a 26-bit history hist of the last 26 bits and form predicted bit p from hist per REQ-014.
REQ-016 FILL: each valid bit shifts din into hist; after the 26th valid bit, state SHALL become VERIFY with match_cnt=0.
REQ-017 VERIFY: each valid bit shifts din into hist (self-synchronising); din==p with hist!=0 increments match_cnt; mismatch or hist==0 resets match_cnt to 0.
REQ-018 VERIFY->LOCKED SHALL occur on the edge sampling the LOCK_MATCH-th consecutive match; locked rises with that same edge.
REQ-019 LOCKED: each valid bit shifts p (not din) into hist (flywheel), so one channel error counts exactly once.
REQ-020 LOCKED mismatch SHALL pulse err_flag for one cycle, increment err_cnt (hold at 16'hFFFF), and increment win_err.
REQ-021 LOCKED: win_cnt counts valid bits 0..WINDOW-1 and wraps; on wrap win_err SHALL reset to 0 (the error on the wrapping bit, if any, counts into the new window).
REQ-022 When win_err reaches LOSS_ERR, state SHALL return to FILL on that edge, locked falls, fill counter, match_cnt, win_cnt, win_err reset; err_cnt retained.
REQ-023 clear SHALL zero err_cnt, win_cnt, win_err; it does not change state; clear wins over a simultaneous error (err_cnt=0) but err_flag still pulses.
REQ-024 din_valid low SHALL hold all registers except err_flag, which returns to 0.
REQ-025 Mismatches in FILL or VERIFY SHALL NOT affect err_cnt or err_flag.

Reset
REQ-026 rst_n low SHALL immediately force state=FILL, hist=0, all counters 0, locked=0, err_flag=0, err_cnt=0, stuck_zero=0.
REQ-027 Reset asserted mid-operation SHALL abandon any lock; after release the block restarts from FILL.

Verification
REQ-028 Clean sequence seeded 26'b01_1001_0011_1000_0011_1111_0010, din_valid=1 continuously -> state=VERIFY after bit 26, locked=1 after bit 58, err_cnt=0 thereafter.
REQ-029 After lock, invert one bit -> exactly one err_flag pulse, err_cnt=1, locked stays 1.
REQ-030 After lock, invert 8 bits within one 64-bit window -> locked falls on the 8th error edge, state=FILL, err_cnt=8; clean data re-locks 58 bits later.
REQ-031 Constant din=0 from reset -> stuck_zero=1 from bit 26 onward, locked never rises, err_cnt=0.
REQ-032 clear asserted on the same edge as a locked mismatch -> err_cnt=0, err_flag=1 for one cycle.
REQ-033 rst_n pulsed low while locked with err_cnt=5 -> locked=0, err_cnt=0 asynchronously; clean data re-locks after 58 bits.
